aes_iter_core: RTL and testbench
================================

AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 SHALL have parameter KEY_BITS, default 128, selecting the key length (128, 192 or 256); any other value SHALL cause an elaboration error.
REQ-002 SHALL derive Nr = 10 / 12 / 14 for KEY_BITS = 128 / 192 / 256.
REQ-003 SHALL have clk input, width 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have rst input, width 1: synchronous, active-high reset.
REQ-005 SHALL have in_valid input, width 1: a key/plaintext pair is offered.
REQ-006 SHALL have in_ready output, width 1: the core can accept a block.
REQ-007 SHALL have key input, width KEY_BITS: the cipher key; bits [KEY_BITS-1:KEY_BITS-8] are key byte 0.
REQ-008 SHALL have plaintext input, width 128: the input block; bits [127:120] are byte 0 (FIPS-197 column-major state order).
REQ-009 SHALL have out_valid output, width 1: ciphertext is valid.
REQ-010 SHALL have out_ready input, width 1: the sink accepts the ciphertext.
REQ-011 SHALL have ciphertext output, width 128: the encrypted block, using the same byte order as plaintext.
REQ-012 SHALL have busy output, width 1: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement FIPS-197 AES encryption for the configured key length, with iterative rounds: one round per clk cycle and on-the-fly key expansion (no precomputed schedule table at the ports).
REQ-014 SHALL implement FSM states IDLE, ROUND and DONE.
REQ-015 SHALL hold in_ready = 1 only in IDLE; a block SHALL be accepted on an edge where in_valid && in_ready.
REQ-016 SHALL, on the acceptance edge: capture key; load state = plaintext XOR round key 0; set round counter = 1; move to ROUND.
REQ-017 SHALL, in ROUND, apply SubBytes, ShiftRows, MixColumns and AddRoundKey(r) on each edge, incrementing the counter.
REQ-018 SHALL omit MixColumns when r = Nr; on that edge the FSM SHALL move to DONE and assert out_valid.
REQ-019 SHALL define round key r as expanded words w[4r..4r+3], with Rcon sequence 01,02,04,08,10,20,40,80,1b,36; for KEY_BITS = 256 SHALL apply the extra SubWord at i mod 8 = 4; for KEY_BITS = 192 SHALL buffer the 6-word key so that round keys straddling the 6-word boundary are correct.
REQ-020 SHALL have latency: out_valid rises exactly Nr cycles after the acceptance edge.
REQ-021 SHALL, in DONE, hold out_valid and ciphertext stable until out_valid && out_ready; on that edge out_valid SHALL drop and the FSM SHALL return to IDLE; in_ready SHALL rise one cycle later (no same-cycle bypass).
REQ-022 SHALL give a minimum block period of Nr+2 cycles with in_valid and out_ready held high.
REQ-023 SHALL ignore in_valid while in_ready = 0; changes to key or plaintext after acceptance SHALL NOT affect the result.
REQ-024 SHALL hold ciphertext at its last value after handshake, until the next DONE.
REQ-025 SHALL give busy = 1 in ROUND and DONE.

Reset
REQ-026 SHALL, when rst = 1 on an edge, set the FSM to IDLE, out_valid = 0, ciphertext = 128'h0, busy = 0, and the round counter = 0.
REQ-027 SHALL hold in_ready = 0 while rst is high and 1 on the first cycle after rst deasserts.
REQ-028 SHALL, on rst mid-operation (ROUND or DONE), abort the block: no out_valid is produced for it, and the next accepted block encrypts correctly.
REQ-029 SHALL give rst priority over any simultaneous handshake.

Verification
REQ-030 SHALL verify KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32; out_valid exactly 10 cycles after acceptance.
REQ-031 SHALL verify KEY_BITS=192, key 000102...1617, pt 00112233445566778899aabbccddeeff -> dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles.
REQ-032 SHALL verify KEY_BITS=256, key 000102...1e1f, same pt -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
REQ-033 SHALL verify backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid and ciphertext stable and in_ready = 0 throughout; in_ready = 1 the cycle after the handshake.
REQ-034 SHALL verify streaming: 3 back-to-back AES-128 blocks with in_valid and out_ready tied high -> correct results at a 12-cycle period; inputs changed mid-block have no effect.
REQ-035 SHALL verify mid-operation reset: rst pulsed at round 5 -> no out_valid, in_ready = 1 next cycle, and a following block gives the correct ciphertext.

Source files
------------

// File: rtl/aes_iter_core.sv
// -----------------------------------------------------------------------------
// aes_iter_core
//
// Iterative AES encryption core (AES-128/192/256 selected by KEY_BITS).
// One cipher round is applied per clock cycle. The key schedule is expanded
// on the fly from a sliding window of the last Nk expanded words, so no
// round-key table is ever stored.
//
// Ports
//   clk         : single clock, all state changes on the rising edge
//   rst         : synchronous active-high reset
//   in_valid    : a key/plaintext pair is offered
//   in_ready    : core is idle and will accept a block on this edge
//   key         : cipher key, bits [KEY_BITS-1 -: 8] are key byte 0
//   plaintext   : input block, bits [127:120] are state byte 0
//   out_valid   : ciphertext is valid, held until out_ready
//   out_ready   : sink accepts the ciphertext
//   ciphertext  : encrypted block, same byte order as plaintext
//   busy        : core is working on or holding a block
// -----------------------------------------------------------------------------
module aes_iter_core #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [KEY_BITS-1:0] key,
   input  logic [127:0]        plaintext,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        ciphertext,
   output logic                busy
);

   localparam int NK = KEY_BITS / 32;   // key length in 32-bit words
   localparam int NR = NK + 6;          // number of rounds: 10 / 12 / 14

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
   end

   // S-box, byte 0x00 in the most significant position
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = 11'd2040 - {b, 3'b000};
      return SBOX_TBL[idx +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] rcon(input int i);
      logic [7:0] r;
      case (i)
         1:       r = 8'h01;
         2:       r = 8'h02;
         3:       r = 8'h04;
         4:       r = 8'h08;
         5:       r = 8'h10;
         6:       r = 8'h20;
         7:       r = 8'h40;
         8:       r = 8'h80;
         9:       r = 8'h1b;
         10:      r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   fsm_t          fsm_q, fsm_d;
   logic [3:0]    round_q, round_d;
   logic [127:0]  state_q, state_d;
   logic [127:0]  cipher_q, cipher_d;

   // Key window: win_q[0..NK-1] = w[g-NK .. g-1], with g = 4*round + NK - 4
   // while round r is about to be applied. Round key r is then always
   // words 4..7 of the sequence {window, next four generated words}.
   logic [31:0]   win_q     [NK];
   logic [31:0]   win_d     [NK];
   logic [31:0]   win_shift [NK];
   logic [31:0]   key_w     [NK];
   logic [31:0]   nw        [4];
   logic [31:0]   rk_w      [4];

   logic [127:0]  sb, sr, mc, rk, round_out;
   logic          last_round;
   logic [3:0]    rnd_m1;
   logic [31:0]   kx_prev, kx_t;
   int            kx_j;

   // ------------------------------------------------------------------
   // Round datapath
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      // ShiftRows: row r of column c takes the byte from column (c + r) mod 4
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
      assign sb[127-8*gi -: 8] = sbox(state_q[127-8*gi -: 8]);
      assign sr[127-8*gi -: 8] = sb[127-8*SRC -: 8];
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr[127-32*gi -: 8];
      assign a1 = sr[119-32*gi -: 8];
      assign a2 = sr[111-32*gi -: 8];
      assign a3 = sr[103-32*gi -: 8];
      assign mc[127-32*gi -: 32] = {
         xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
         a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
         a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
         xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
   end

   assign last_round = (round_q == 4'(NR));
   assign rk         = {rk_w[0], rk_w[1], rk_w[2], rk_w[3]};
   assign round_out  = (last_round ? sr : mc) ^ rk;

   // ------------------------------------------------------------------
   // On-the-fly key expansion: four new words per cycle
   // ------------------------------------------------------------------
   assign rnd_m1 = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;

   always_comb begin
      kx_prev = win_q[NK-1];
      kx_t    = 32'h0;
      kx_j    = 0;
      for (int k = 0; k < 4; k++) begin
         // kx_j = (word index - NK); its residue mod NK selects the rule
         kx_j = 4 * int'(rnd_m1) + k;
         kx_t = kx_prev;
         if (kx_j % NK == 0)
            kx_t = sub_word(rot_word(kx_prev)) ^ {rcon(1 + kx_j / NK), 24'h000000};
         else if (NK == 8 && kx_j % NK == 4)
            kx_t = sub_word(kx_prev);
         nw[k]   = win_q[k] ^ kx_t;
         kx_prev = nw[k];
      end
   end

   for (genvar gi = 0; gi < NK; gi++) begin : g_win
      assign key_w[gi] = key[KEY_BITS-1-32*gi -: 32];
      if (gi < NK - 4) begin : g_old
         assign win_shift[gi] = win_q[gi+4];
      end else begin : g_new
         assign win_shift[gi] = nw[gi-(NK-4)];
      end
   end

   // For AES-192 the round key straddles the old window and the new words
   for (genvar gi = 0; gi < 4; gi++) begin : g_rk
      if (4 + gi < NK) begin : g_from_win
         assign rk_w[gi] = win_q[4+gi];
      end else begin : g_from_new
         assign rk_w[gi] = nw[4+gi-NK];
      end
   end

   // ------------------------------------------------------------------
   // Control
   // ------------------------------------------------------------------
   assign in_ready   = (fsm_q == IDLE) && !rst;
   assign out_valid  = (fsm_q == DONE);
   assign busy       = (fsm_q != IDLE);
   assign ciphertext = cipher_q;

   always_comb begin
      fsm_d    = fsm_q;
      round_d  = round_q;
      state_d  = state_q;
      cipher_d = cipher_q;
      win_d    = win_q;
      case (fsm_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               fsm_d   = ROUND;
               round_d = 4'd1;
               state_d = plaintext ^ key[KEY_BITS-1 -: 128];
               win_d   = key_w;
            end
         end
         ROUND: begin
            state_d = round_out;
            win_d   = win_shift;
            if (last_round) begin
               fsm_d    = DONE;
               cipher_d = round_out;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         DONE: begin
            if (out_ready)
               fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q    <= IDLE;
         round_q  <= 4'd0;
         cipher_q <= 128'h0;
      end else begin
         fsm_q    <= fsm_d;
         round_q  <= round_d;
         cipher_q <= cipher_d;
      end
   end

   // Working state and key window are always reloaded on acceptance
   always_ff @(posedge clk) begin
      state_q <= state_d;
      win_q   <= win_d;
   end

endmodule

// File: tb/tb_aes_iter_core.sv
// -----------------------------------------------------------------------------
// tb_aes_iter_core
//
// Self-checking bench for aes_iter_core. Three instances (AES-128/192/256)
// share clock, reset, key bus, plaintext and out_ready; each has its own
// in_valid. Known-answer vectors come from FIPS-197 plus the all-zero
// AES-128 vector.
// -----------------------------------------------------------------------------
module tb_aes_iter_core;

   logic          clk = 1'b0;
   logic          rst;
   logic [255:0]  key_bus;
   logic [127:0]  pt;
   logic          out_ready;
   logic [2:0]    in_valid_v;
   logic [2:0]    in_ready_v;
   logic [2:0]    out_valid_v;
   logic [2:0]    busy_v;
   logic [127:0]  ct_v [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   aes_iter_core #(.KEY_BITS(128)) u_aes128 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid_v[0]),
      .in_ready   (in_ready_v[0]),
      .key        (key_bus[255:128]),
      .plaintext  (pt),
      .out_valid  (out_valid_v[0]),
      .out_ready  (out_ready),
      .ciphertext (ct_v[0]),
      .busy       (busy_v[0])
   );

   aes_iter_core #(.KEY_BITS(192)) u_aes192 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid_v[1]),
      .in_ready   (in_ready_v[1]),
      .key        (key_bus[255:64]),
      .plaintext  (pt),
      .out_valid  (out_valid_v[1]),
      .out_ready  (out_ready),
      .ciphertext (ct_v[1]),
      .busy       (busy_v[1])
   );

   aes_iter_core #(.KEY_BITS(256)) u_aes256 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid_v[2]),
      .in_ready   (in_ready_v[2]),
      .key        (key_bus),
      .plaintext  (pt),
      .out_valid  (out_valid_v[2]),
      .out_ready  (out_ready),
      .ciphertext (ct_v[2]),
      .busy       (busy_v[2])
   );

   typedef struct {
      int            sel;
      logic [255:0]  key;
      logic [127:0]  pt;
      logic [127:0]  ct;
      int            nr;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full block: offer, wait bounded for out_valid, check, handshake.
   task automatic run_block(input vec_t v, input string tag);
      int n;
      @(negedge clk);
      check({tag, " in_ready before offer"}, 128'(in_ready_v[v.sel]), 128'd1);
      key_bus           = v.key;
      pt                = v.pt;
      in_valid_v[v.sel] = 1'b1;
      out_ready         = 1'b1;
      @(negedge clk);
      // acceptance edge has passed; scramble inputs, result must not change
      in_valid_v[v.sel] = 1'b0;
      key_bus           = ~v.key;
      pt                = ~v.pt;
      check({tag, " busy after accept"}, 128'(busy_v[v.sel]), 128'd1);
      check({tag, " in_ready after accept"}, 128'(in_ready_v[v.sel]), 128'd0);
      n = 0;
      while (!out_valid_v[v.sel] && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, 128'(n), 128'(v.nr));
      check({tag, " ciphertext"}, ct_v[v.sel], v.ct);
      $display("block %s key_bits=%0d latency=%0d ct=%h", tag, 128 + 64 * v.sel, n, ct_v[v.sel]);
      @(negedge clk);
      check({tag, " out_valid after handshake"}, 128'(out_valid_v[v.sel]), 128'd0);
      check({tag, " in_ready after handshake"}, 128'(in_ready_v[v.sel]), 128'd1);
      check({tag, " ciphertext held"}, ct_v[v.sel], v.ct);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seen;
      int cyc;
      int acc;
      int got;
      int last_out;
      bit pend;

      vecs[0] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                  128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 10};
      vecs[1] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                  128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10};
      vecs[2] = '{0, 256'h0,
                  128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 10};
      vecs[3] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                  128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 12};
      vecs[4] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 14};

      // ---------------- reset ----------------
      rst        = 1'b1;
      in_valid_v = 3'b000;
      out_ready  = 1'b0;
      key_bus    = '0;
      pt         = '0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         check($sformatf("reset in_ready[%0d]", s), 128'(in_ready_v[s]), 128'd0);
         check($sformatf("reset out_valid[%0d]", s), 128'(out_valid_v[s]), 128'd0);
         check($sformatf("reset busy[%0d]", s), 128'(busy_v[s]), 128'd0);
         check($sformatf("reset ciphertext[%0d]", s), ct_v[s], 128'h0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 3; s++)
         check($sformatf("in_ready after reset[%0d]", s), 128'(in_ready_v[s]), 128'd1);
      $display("reset released");

      // ---------------- known-answer table ----------------
      for (int i = 0; i < 5; i++)
         run_block(vecs[i], $sformatf("vec%0d", i));

      // ---------------- backpressure ----------------
      @(negedge clk);
      key_bus       = vecs[1].key;
      pt            = vecs[1].pt;
      in_valid_v[0] = 1'b1;
      out_ready     = 1'b0;
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      n = 0;
      while (!out_valid_v[0] && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("bp latency", 128'(n), 128'd10);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid_v[0] = 1'b1;   // must be ignored while not ready
         check($sformatf("bp out_valid c%0d", c), 128'(out_valid_v[0]), 128'd1);
         check($sformatf("bp ciphertext c%0d", c), ct_v[0], vecs[1].ct);
         check($sformatf("bp in_ready c%0d", c), 128'(in_ready_v[0]), 128'd0);
      end
      in_valid_v[0] = 1'b0;
      out_ready     = 1'b1;
      @(negedge clk);
      check("bp out_valid after handshake", 128'(out_valid_v[0]), 128'd0);
      check("bp in_ready after handshake", 128'(in_ready_v[0]), 128'd1);
      $display("block backpressure ct=%h", ct_v[0]);

      // ---------------- streaming ----------------
      @(negedge clk);
      key_bus       = vecs[0].key;
      pt            = vecs[0].pt;
      in_valid_v[0] = 1'b1;
      out_ready     = 1'b1;
      pend          = (in_ready_v[0] == 1'b1);
      cyc = 0; acc = 0; got = 0; last_out = 0;
      while (got < 3 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (pend) begin
            acc++;
            key_bus = ~vecs[acc-1].key ^ 256'h5a5a;
            pt      = ~vecs[acc-1].pt;
            if (acc == 3)
               in_valid_v[0] = 1'b0;
            pend = 1'b0;
         end
         if (out_valid_v[0]) begin
            check($sformatf("stream ct%0d", got), ct_v[0], vecs[got].ct);
            if (got > 0)
               check($sformatf("stream period%0d", got), 128'(cyc - last_out), 128'd12);
            $display("block stream%0d cycle=%0d ct=%h", got, cyc, ct_v[0]);
            last_out = cyc;
            got++;
            if (acc < 3) begin
               key_bus = vecs[acc].key;
               pt      = vecs[acc].pt;
            end
         end
         if (in_ready_v[0] && in_valid_v[0])
            pend = 1'b1;
      end
      check("stream blocks seen", 128'(got), 128'd3);
      in_valid_v[0] = 1'b0;

      // ---------------- mid-operation reset ----------------
      @(negedge clk);
      key_bus       = vecs[1].key;
      pt            = vecs[1].pt;
      in_valid_v[0] = 1'b1;
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst in_ready while rst", 128'(in_ready_v[0]), 128'd0);
      check("midrst busy before edge", 128'(busy_v[0]), 128'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst busy after", 128'(busy_v[0]), 128'd0);
      check("midrst in_ready after", 128'(in_ready_v[0]), 128'd1);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid_v[0])
            seen++;
      end
      check("midrst no out_valid", 128'(seen), 128'd0);
      $display("block midrst aborted out_valid_count=%0d", seen);
      run_block(vecs[0], "after_midrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
